mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle RISC-V control FSM with memory wait timeout and trap state
module mc_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [6:0]  Op,
    input  logic [2:0]  Funct3,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MDRWrite,
    output logic        PCSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSel,
    output logic [1:0]  WDSel,
    output logic [2:0]  state,
    output logic [31:0] instret,
    output logic        trap,
    output logic        bus_err
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [10:0] TIMEOUT_W = 11'(TIMEOUT);

    state_t      state_q, state_d;
    logic [9:0]  wait_q, wait_d;
    logic [31:0] instret_q, instret_d;
    logic        bus_err_q, bus_err_d;

    logic is_alu, is_auipc, is_load, is_store, is_branch, is_jal, is_jalr, legal;
    logic req_c, we_c, iord_c, irw_c, pcw_c, rw_c, mdrw_c, pcsrc_c, srca_c, trap_c;
    logic [1:0] alusel_c, wdsel_c;
    logic mem_wait, timeout_hit, retire;

    assign is_alu    = (Op == OP_R) || (Op == OP_I) || (Op == OP_LUI);
    assign is_auipc  = (Op == OP_AUIPC);
    assign is_load   = (Op == OP_LOAD);
    assign is_store  = (Op == OP_STORE);
    assign is_branch = (Op == OP_BR);
    assign is_jal    = (Op == OP_JAL);
    assign is_jalr   = (Op == OP_JALR);
    assign legal     = is_alu | is_auipc | is_load | is_store | is_branch | is_jal | is_jalr;

    // Ready in the cycle the count would hit TIMEOUT still completes the access.
    assign mem_wait    = req_c & ~mem_ready;
    assign timeout_hit = mem_wait && (({1'b0, wait_q} + 11'd1) >= TIMEOUT_W);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus_err_d = bus_err_q;
        retire    = 1'b0;
        req_c     = 1'b0;
        we_c      = 1'b0;
        iord_c    = 1'b0;
        irw_c     = 1'b0;
        pcw_c     = 1'b0;
        rw_c      = 1'b0;
        mdrw_c    = 1'b0;
        pcsrc_c   = 1'b0;
        srca_c    = 1'b0;
        alusel_c  = 2'b00;
        wdsel_c   = 2'b00;
        trap_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_alu || is_auipc) begin
                    alusel_c = 2'b01;
                    srca_c   = ~is_auipc;
                    state_d  = S_WB;
                end else if (is_load || is_store) begin
                    srca_c  = 1'b1;
                    state_d = S_MEM;
                end else if (is_branch) begin
                    alusel_c = 2'b10;
                    srca_c   = 1'b1;
                    pcw_c    = Zero;
                    pcsrc_c  = Zero;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_jal) begin
                    pcw_c   = 1'b1;
                    pcsrc_c = 1'b1;
                    state_d = S_WB;
                end else if (is_jalr) begin
                    srca_c  = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_WB;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM: begin
                req_c  = 1'b1;
                iord_c = 1'b1;
                we_c   = is_store;
                if (mem_ready) begin
                    if (is_load) begin
                        mdrw_c  = 1'b1;
                        state_d = S_WB;
                    end else if (is_store) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_TRAP;
                    end
                end else if (timeout_hit) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_WB: begin
                rw_c    = 1'b1;
                wdsel_c = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  trap_c = 1'b1;
            default: state_d = S_TRAP;
        endcase
        wait_d    = mem_wait ? (wait_q + 10'd1) : 10'd0;
        instret_d = instret_q + {31'd0, retire};
    end

    // Strobes are combinational, so they are gated directly to die with reset.
    assign mem_req  = rstn & req_c;
    assign mem_we   = rstn & we_c;
    assign IorD     = rstn & iord_c;
    assign IRWrite  = rstn & irw_c;
    assign PCWrite  = rstn & pcw_c;
    assign RegWrite = rstn & rw_c;
    assign MDRWrite = rstn & mdrw_c;
    assign PCSrc    = rstn & pcsrc_c;
    assign ALUSrcA  = rstn & srca_c;
    assign ALUSel   = rstn ? alusel_c : 2'b00;
    assign WDSel    = rstn ? wdsel_c : 2'b00;
    assign trap     = rstn & trap_c;
    assign bus_err  = bus_err_q;
    assign state    = state_q;
    assign instret  = instret_q;

    logic unused_funct3;
    assign unused_funct3 = ^Funct3;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed-vector bench for mc_ctrl
module tb_mc_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic [6:0]  Op;
    logic [2:0]  Funct3;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, MDRWrite, PCSrc, ALUSrcA;
    logic [1:0]  ALUSel, WDSel;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        trap, bus_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct3(Funct3), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MDRWrite(MDRWrite),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSel(ALUSel), .WDSel(WDSel),
        .state(state), .instret(instret), .trap(trap), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        rstn = 1'b0; Op = 7'b0110011; Funct3 = 3'd5; Zero = 1'b0; mem_ready = 1'b1;
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_irwrite", 32'(IRWrite), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        rstn = 1'b1;
        #1;

        // add
        chk("add_f_state", 32'(state), 32'd0);
        chk("add_f_req", 32'(mem_req), 32'd1);
        chk("add_f_irw", 32'(IRWrite), 32'd1);
        chk("add_f_pcw", 32'(PCWrite), 32'd1);
        tick();
        chk("add_d_state", 32'(state), 32'd1);
        tick();
        chk("add_e_state", 32'(state), 32'd2);
        chk("add_e_alusel", 32'(ALUSel), 32'd1);
        chk("add_e_srca", 32'(ALUSrcA), 32'd1);
        tick();
        chk("add_w_state", 32'(state), 32'd4);
        chk("add_w_regw", 32'(RegWrite), 32'd1);
        chk("add_w_wdsel", 32'(WDSel), 32'd0);
        chk("add_w_instret", instret, 32'd0);
        tick();
        chk("add_done_state", 32'(state), 32'd0);
        chk("add_done_regw", 32'(RegWrite), 32'd0);
        chk("add_instret", instret, 32'd1);

        // lw, ready held off 3 cycles in MEM
        Op = 7'b0000011;
        tick(); tick();
        chk("lw_e_state", 32'(state), 32'd2);
        chk("lw_e_alusel", 32'(ALUSel), 32'd0);
        chk("lw_e_srca", 32'(ALUSrcA), 32'd1);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_m_state", 32'(state), 32'd3);
            chk("lw_m_req", 32'(mem_req), 32'd1);
            chk("lw_m_iord", 32'(IorD), 32'd1);
            chk("lw_m_we", 32'(mem_we), 32'd0);
            chk("lw_m_mdrw_wait", 32'(MDRWrite), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_m4_req", 32'(mem_req), 32'd1);
        chk("lw_m4_mdrw", 32'(MDRWrite), 32'd1);
        tick();
        chk("lw_w_state", 32'(state), 32'd4);
        chk("lw_w_wdsel", 32'(WDSel), 32'd1);
        chk("lw_w_mdrw", 32'(MDRWrite), 32'd0);
        tick();
        chk("lw_instret", instret, 32'd2);

        // beq taken then not taken
        Op = 7'b1100011; Zero = 1'b1;
        tick(); tick();
        chk("beq1_state", 32'(state), 32'd2);
        chk("beq1_pcw", 32'(PCWrite), 32'd1);
        chk("beq1_pcsrc", 32'(PCSrc), 32'd1);
        chk("beq1_alusel", 32'(ALUSel), 32'd2);
        tick();
        chk("beq1_ret_state", 32'(state), 32'd0);
        chk("beq1_instret", instret, 32'd3);
        Zero = 1'b0;
        tick(); tick();
        chk("beq0_pcw", 32'(PCWrite), 32'd0);
        tick();
        chk("beq0_instret", instret, 32'd4);

        // sw aborted by reset while in MEM
        Op = 7'b0100011;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        chk("sw_m_state", 32'(state), 32'd3);
        chk("sw_m_we", 32'(mem_we), 32'd1);
        rstn = 1'b0;
        #1;
        chk("sw_rst_req", 32'(mem_req), 32'd0);
        chk("sw_rst_we", 32'(mem_we), 32'd0);
        chk("sw_rst_state", 32'(state), 32'd0);
        chk("sw_rst_instret", instret, 32'd0);
        tick();
        rstn = 1'b1;
        #1;
        chk("sw_restart_state", 32'(state), 32'd0);
        chk("sw_restart_req", 32'(mem_req), 32'd1);

        // fetch timeout with TIMEOUT=4
        Op = 7'b0110011;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_state", 32'(state), 32'd0);
            tick();
        end
        chk("to_state", 32'(state), 32'd5);
        chk("to_trap", 32'(trap), 32'd1);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_req", 32'(mem_req), 32'd0);
        do_reset();
        chk("to_clr_bus_err", 32'(bus_err), 32'd0);

        // ready arrives on the 4th wait cycle: completes
        for (int i = 0; i < 3; i++) tick();
        mem_ready = 1'b1;
        #1;
        chk("late_irw", 32'(IRWrite), 32'd1);
        tick();
        chk("late_state", 32'(state), 32'd1);
        chk("late_trap", 32'(trap), 32'd0);
        tick(); tick(); tick();
        chk("late_instret", instret, 32'd1);

        // illegal opcode
        Op = 7'b1111111;
        tick();
        chk("ill_d_state", 32'(state), 32'd1);
        tick();
        chk("ill_state", 32'(state), 32'd5);
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_bus_err", 32'(bus_err), 32'd0);
        Op = 7'b0110011;
        for (int i = 0; i < 20; i++) tick();
        chk("ill_hold_state", 32'(state), 32'd5);
        chk("ill_hold_trap", 32'(trap), 32'd1);
        chk("ill_hold_req", 32'(mem_req), 32'd0);
        chk("ill_instret", instret, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
